// File: rtl/apb_cmd_initiator.sv
// apb_cmd_initiator: turns a valid/ready command stream into APB SETUP/ACCESS transfers
// and returns read data/error on a valid/ready response channel, with a bounded pready wait.
module apb_cmd_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_prot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic [2:0]        pprot,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);
    localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              psel_q, penable_q, pwrite_q, rsp_valid_q, rsp_err_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
    logic [2:0]        pprot_q;
    logic              timed_out;

    assign timed_out = (TIMEOUT != 0) && (cnt_q == LIMIT);
    assign req_ready = (state_q == IDLE) && !preset;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    paddr_q  <= req_addr;
                    pwrite_q <= req_write;
                    pwdata_q <= req_wdata;
                    pprot_q  <= req_prot;
                    psel_q   <= 1'b1;
                    state_q  <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: if (pready || timed_out) begin
                    // pready wins over a timeout landing on the same cycle
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= pready ? pslverr : 1'b1;
                    rsp_rdata_q <= (pready && !pwrite_q) ? prdata : '0;
                    state_q     <= RESP;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pprot     = pprot_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule
